// File: rtl/cam_cfg_sequencer.sv
// Camera sensor configuration sequencer: walks a per-profile register table, issuing SCCB
// writes with per-entry retry, embedded delays and an end marker.
module cam_cfg_sequencer #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned NUM_PROFILES = 2,
  parameter int unsigned TICK_CYCLES  = 27000,
  parameter int unsigned MAX_RETRY    = 3,
  localparam int unsigned PW  = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1,
  localparam int unsigned RAW = (NUM_PROFILES * DEPTH > 1) ? $clog2(NUM_PROFILES * DEPTH) : 1,
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [PW-1:0]            profile,
  output logic [RAW-1:0]           rom_addr,
  input  logic [ADDR_W+DATA_W-1:0] rom_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [ADDR_W-1:0]        cmd_reg,
  output logic [DATA_W-1:0]        cmd_data,
  input  logic                     resp_valid,
  input  logic                     resp_err,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [IW-1:0]            err_index
);

  // Sized so that (2^DATA_W - 1) * TICK_CYCLES always fits.
  localparam int unsigned CW = DATA_W + $clog2(TICK_CYCLES + 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StWaitResp,
    StDelay,
    StDone,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     prof_q, prof_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [CW-1:0]     dly_q, dly_d;
  logic [ADDR_W-1:0] reg_q, reg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IW-1:0]     err_idx_q, err_idx_d;

  logic [ADDR_W-1:0] ent_reg;
  logic [DATA_W-1:0] ent_data;
  logic              last_idx;
  logic              advance;

  assign ent_reg  = rom_data[ADDR_W+DATA_W-1:DATA_W];
  assign ent_data = rom_data[DATA_W-1:0];
  assign last_idx = (idx_q == IW'(DEPTH - 1));

  always_comb begin
    state_d   = state_q;
    prof_d    = prof_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    dly_d     = dly_q;
    reg_d     = reg_q;
    data_d    = data_q;
    err_idx_d = err_idx_q;
    advance   = 1'b0;

    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d   = StFetch;
          prof_d    = profile;
          idx_d     = '0;
          retry_d   = '0;
          err_idx_d = '0;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (&rom_data) begin
          state_d = StDone;
        end else if (&ent_reg) begin
          if (ent_data == '0) begin
            advance = 1'b1;
          end else begin
            dly_d   = CW'(ent_data) * CW'(TICK_CYCLES);
            state_d = StDelay;
          end
        end else begin
          reg_d   = ent_reg;
          data_d  = ent_data;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (cmd_ready) state_d = StWaitResp;
      end
      StWaitResp: begin
        if (resp_valid) begin
          if (!resp_err) begin
            advance = 1'b1;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            // cmd_reg/cmd_data still hold the failed entry, so reissue directly.
            retry_d = retry_q + RW'(1);
            state_d = StIssue;
          end else begin
            err_idx_d = idx_q;
            state_d   = StError;
          end
        end
      end
      StDelay: begin
        if (dly_q <= CW'(1)) begin
          dly_d   = '0;
          advance = 1'b1;
        end else begin
          dly_d = dly_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // The last table slot ends the sequence rather than spilling into the next profile.
    if (advance) begin
      retry_d = '0;
      if (last_idx) begin
        state_d = StDone;
      end else begin
        idx_d   = idx_q + IW'(1);
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      prof_q    <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      dly_q     <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      prof_q    <= prof_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      dly_q     <= dly_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign rom_addr  = RAW'(32'(prof_q) * DEPTH + 32'(idx_q));
  assign cmd_valid = (state_q == StIssue);
  assign cmd_reg   = reg_q;
  assign cmd_data  = data_q;
  assign busy      = (state_q == StFetch) || (state_q == StDecode) || (state_q == StIssue) ||
                     (state_q == StWaitResp) || (state_q == StDelay);
  assign done      = (state_q == StDone);
  assign error     = (state_q == StError);
  assign err_index = err_idx_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Directed bench for cam_cfg_sequencer: table ROM model, auto-responding SCCB side and a
// command scoreboard filled as each table is loaded.
module tb_cam_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [0:0]  profile;
  logic [2:0]  rom_addr;
  logic [15:0] rom_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_reg;
  logic [7:0]  cmd_data;
  logic        resp_valid;
  logic        resp_err;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_index;

  logic [15:0] rom [0:7];
  logic [15:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_issued;

  cam_cfg_sequencer #(
    .ADDR_W      (8),
    .DATA_W      (8),
    .DEPTH       (4),
    .NUM_PROFILES(2),
    .TICK_CYCLES (10),
    .MAX_RETRY   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .profile   (profile),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_reg   (cmd_reg),
    .cmd_data  (cmd_data),
    .resp_valid(resp_valid),
    .resp_err  (resp_err),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (err_index)
  );

  always #5 clk = ~clk;

  // Synchronous table ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = 16'hFFFF;
    exp_q.delete();
    n_issued = 0;
  endtask

  task automatic do_start(input logic p);
    profile = p;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({pfx, "_busy"},      32'(busy),      32'd0);
    check({pfx, "_done"},      32'(done),      32'd0);
    check({pfx, "_error"},     32'(error),     32'd0);
    check({pfx, "_rom_addr"},  32'(rom_addr),  32'd0);
    check({pfx, "_cmd_reg"},   32'(cmd_reg),   32'd0);
    check({pfx, "_cmd_data"},  32'(cmd_data),  32'd0);
    check({pfx, "_err_index"}, 32'(err_index), 32'd0);
  endtask

  // Accept commands while busy, answer each one cycle after its handshake; the first
  // `errs` answers are NACKs. Issued commands are checked against the scoreboard.
  task automatic service(input int max_cyc, input int errs);
    int          n_err;
    int          c;
    bit          hs;
    logic [15:0] e;
    n_err = errs;
    hs    = 1'b0;
    c     = 0;
    while (busy && c < max_cyc) begin
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      if (hs) begin
        resp_valid = 1'b1;
        resp_err   = (n_err > 0);
        if (n_err > 0) n_err--;
        hs = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        n_issued++;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 16'hDEAD;
        check("sb_cmd", 32'({cmd_reg, cmd_data}), 32'(e));
        hs = 1'b1;
      end
      tick();
      c++;
    end
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    check("service_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    bit saw_valid;
    rst_n      = 1'b0;
    start      = 1'b0;
    profile    = 1'b0;
    cmd_ready  = 1'b1;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    clear_rom();
    tick();
    tick();
    check_reset("rst0");
    rst_n = 1'b1;
    tick();

    // Two writes then end marker; first cmd_valid three cycles after start.
    clear_rom();
    rom[0] = 16'h1280;
    rom[1] = 16'h1180;
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1180);
    do_start(1'b0);
    check("t1_busy_fetch", 32'(busy), 32'd1);
    check("t1_addr_fetch", 32'(rom_addr), 32'd0);
    check("t1_valid_c1", 32'(cmd_valid), 32'd0);
    tick();
    check("t1_valid_c2", 32'(cmd_valid), 32'd0);
    tick();
    check("t1_valid_c3", 32'(cmd_valid), 32'd1);
    service(100, 0);
    check("t1_done", 32'(done), 32'd1);
    check("t1_issued", 32'(n_issued), 32'd2);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Profile 1 delay of 2 ticks = 20 cycles in DELAY.
    clear_rom();
    rom[4] = 16'hFF02;
    rom[5] = 16'h3344;
    exp_q.push_back(16'h3344);
    do_start(1'b1);
    n = 0;
    saw_valid = 1'b0;
    while (rom_addr == 3'd4 && n < 100) begin
      if (cmd_valid) saw_valid = 1'b1;
      n++;
      tick();
    end
    check("t2_cycles_on_entry0", 32'(n), 32'd22);
    check("t2_no_valid_in_delay", 32'(saw_valid), 32'd0);
    check("t2_next_fetch_addr", 32'(rom_addr), 32'd5);
    service(100, 0);
    check("t2_done", 32'(done), 32'd1);
    check("t2_issued", 32'(n_issued), 32'd1);

    // Zero delay skips DELAY; four NACKs on 15_00 exhaust retries at index 1.
    clear_rom();
    rom[0] = 16'hFF00;
    rom[1] = 16'h1500;
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h1500);
    do_start(1'b0);
    n = 1;
    while (!cmd_valid && n < 50) begin
      tick();
      n++;
    end
    check("t3_zero_delay_latency", 32'(n), 32'd5);
    service(200, 4);
    check("t3_error", 32'(error), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    check("t3_err_index", 32'(err_index), 32'd1);
    check("t3_issued", 32'(n_issued), 32'd4);

    // Stall five cycles; stray start and resp during ISSUE are ignored.
    clear_rom();
    rom[0] = 16'h2211;
    exp_q.push_back(16'h2211);
    cmd_ready = 1'b0;
    do_start(1'b0);
    check("t4_error_cleared", 32'(error), 32'd0);
    check("t4_err_index_cleared", 32'(err_index), 32'd0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_valid", 32'(cmd_valid), 32'd1);
      check("t4_stall_payload", 32'({cmd_reg, cmd_data}), 32'h2211);
      start      = (i == 1);
      profile    = 1'b1;
      resp_valid = (i == 2);
      resp_err   = (i == 2);
      tick();
    end
    start      = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    check("t4_profile_kept", 32'(rom_addr), 32'd0);
    check("t4_still_valid", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    service(100, 0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_issued", 32'(n_issued), 32'd1);

    // No end marker: four commands from profile 1, index never wraps.
    clear_rom();
    rom[4] = 16'h3001;
    rom[5] = 16'h3102;
    rom[6] = 16'h3203;
    rom[7] = 16'h3304;
    for (int i = 0; i < 4; i++) exp_q.push_back(rom[4+i]);
    do_start(1'b1);
    service(200, 0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_issued", 32'(n_issued), 32'd4);
    check("t5_last_addr", 32'(rom_addr), 32'd7);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset during WAIT_RESP and during DELAY, then restart from index 0.
    clear_rom();
    rom[0] = 16'h4455;
    do_start(1'b0);
    tick();
    tick();
    check("t6_issue_valid", 32'(cmd_valid), 32'd1);
    tick();
    check("t6_wait_busy", 32'(busy), 32'd1);
    check("t6_wait_no_valid", 32'(cmd_valid), 32'd0);
    rst_n = 1'b0;
    tick();
    check_reset("t6_rst_wait");
    rst_n = 1'b1;
    tick();
    rom[4] = 16'hFF05;
    do_start(1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("t6_delay_busy", 32'(busy), 32'd1);
    check("t6_delay_addr", 32'(rom_addr), 32'd4);
    rst_n = 1'b0;
    tick();
    check_reset("t6_rst_delay");
    rst_n = 1'b1;
    tick();
    do_start(1'b1);
    check("t6_restart_addr", 32'(rom_addr), 32'd4);
    service(200, 0);
    check("t6_done", 32'(done), 32'd1);
    check("t6_issued", 32'(n_issued), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
